seq_shift_add_multiplier: RTL and testbench
===========================================

Name: seq_shift_add_multiplier

Overview:
Parametrised sequential radix-2 shift-add multiplier. It supports optional signed (two's-complement) operation and a start/busy/done handshake. It replaces the purely combinational unrolled multiplier and computes one multiplier bit per clock, which cuts area for wide operands. It sits between a control FSM that issues operands and a consumer that samples the result on o_Done.

Parameters:
A_WIDTH, 9, width of multiplicand i_Val1 (>=2)
B_WIDTH, 5, width of multiplier i_Val2 (>=2); equals the number of RUN cycles
SIGNED_EN, 1, 1 = i_Signed honoured; 0 = i_Signed ignored, always unsigned

Ports:
i_Clk  in  1  clock, all logic on rising edge
i_Rst_n  in  1  synchronous active-low reset
i_Start  in  1  request; accepted only when o_Busy=0
i_Signed  in  1  1 = operands are two's complement (sampled with i_Start)
i_Val1  in  A_WIDTH  multiplicand (sampled with i_Start)
i_Val2  in  B_WIDTH  multiplier (sampled with i_Start)
o_Busy  out  1  high while an operation is in progress
o_Done  out  1  one-cycle pulse: o_Result is valid and new
o_Result  out  A_WIDTH+B_WIDTH  full-width product, held until the next completion

Behaviour:
- Reset (i_Rst_n=0 at a rising edge): state=IDLE; o_Busy=0, o_Done=0, o_Result=0; internal accumulator, shift registers and counter cleared. Reset mid-operation aborts the operation with no o_Done.
- States: IDLE, RUN, FIX. o_Busy = (state != IDLE), registered.
- IDLE: on i_Start=1 at edge k, latch the operands and the sign mode:
  - signed_op = i_Signed & SIGNED_EN.
  - If signed_op, latch |i_Val1| and |i_Val2| as unsigned magnitudes, and neg = sign(Val1) XOR sign(Val2).
  - The most-negative value's magnitude (2^(W-1)) fits in W unsigned bits.
  - Clear the accumulator, set count=0, go to RUN.
- RUN: one cycle per multiplier bit, LSB first:
  - If mult[0]=1, acc += mcand (mcand zero-extended to A_WIDTH+B_WIDTH).
  - mcand <<= 1; mult >>= 1; count++.
  - After B_WIDTH cycles (count == B_WIDTH-1 on that edge), go to FIX.
- FIX (one cycle): o_Result <= neg ? -acc : acc, modulo 2^(A_WIDTH+B_WIDTH); o_Done <= 1; state <= IDLE.
- Latency: start accepted at edge k; o_Done is high during the cycle after edge k+B_WIDTH+1. Default = 7 cycles.
- o_Done is high exactly one cycle per operation, otherwise 0.
- i_Start while o_Busy=1 is ignored. Operands are not re-sampled and no queueing occurs.
- Back-to-back: i_Start during the o_Done cycle (state is IDLE) is accepted. Throughput is one result per B_WIDTH+2 cycles.
- Input changes after acceptance have no effect on the running operation.
- Widths: the product never overflows A_WIDTH+B_WIDTH bits. The worst signed case is (-2^(A-1))·(-2^(B-1)) = 2^(A+B-2).
- Zero operand: still runs the full B_WIDTH cycles; result 0; neg forced to 0 when the result is 0, so there is no negative zero.
- Unsigned mode: operands are zero-extended; no negation.

Decomposition:
- Package mult_pkg: state enum (IDLE, RUN, FIX), helper function for two's-complement magnitude, and localparam P_WIDTH = A_WIDTH+B_WIDTH as a function/macro.
- Single module; no sub-module is needed. The count register is $clog2(B_WIDTH) bits wide.

Test Plan:
- Unsigned, defaults: Val1=511, Val2=31, Signed=0 -> after 7 cycles o_Done=1 for one cycle, o_Result=15841 (14'h3DE1); o_Busy high for 6 cycles.
- Signed extremes: Val1=9'h100 (-256), Val2=5'h10 (-16), Signed=1 -> o_Result=4096 (14'h1000); Val1=-1, Val2=15 -> o_Result=14'h3FF1 (-15).
- Zero/identity: Val1=0, Val2=31 -> 0 (no negative zero in signed mode); Val1=300, Val2=1 -> 300.
- Start while busy: second i_Start with different operands at cycle 3 -> ignored; single o_Done with the first result; then i_Start held during the o_Done cycle -> accepted, second result 7 cycles later.
- Reset mid-op: i_Rst_n=0 at cycle 3 of RUN -> next cycle o_Busy=0, o_Result=0; no o_Done ever appears for the aborted operation.
- Parameter sweep: A_WIDTH=16, B_WIDTH=8, SIGNED_EN=0 -> random 1000 operand pairs match a reference product; i_Signed=1 is ignored; latency is 10 cycles.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
`default_nettype none

package mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Full product width; written as a function so each instance can size its own ports.
  function automatic int p_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  // Two's-complement magnitude. The caller sign-extends into 64 bits and truncates back,
  // so the most-negative value comes out as the unsigned magnitude 2^(W-1).
  function automatic logic [63:0] mag64(input logic [63:0] v);
    return v[63] ? (~v + 64'd1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_shift_add_multiplier.sv
// Radix-2 sequential shift-add multiplier with optional signed mode.
// One multiplier bit is consumed per clock, followed by one sign-fixup cycle.
`default_nettype none

module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int A_WIDTH   = 9,
  parameter int B_WIDTH   = 5,
  parameter int SIGNED_EN = 1
) (
  input  logic                              i_Clk,
  input  logic                              i_Rst_n,
  input  logic                              i_Start,
  input  logic                              i_Signed,
  input  logic [A_WIDTH-1:0]                i_Val1,
  input  logic [B_WIDTH-1:0]                i_Val2,
  output logic                              o_Busy,
  output logic                              o_Done,
  output logic [p_width(A_WIDTH,B_WIDTH)-1:0] o_Result
);

  localparam int P_WIDTH = p_width(A_WIDTH, B_WIDTH);
  localparam int CNT_W   = (B_WIDTH > 2) ? $clog2(B_WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(B_WIDTH - 1);

  state_t               r_state;
  logic [P_WIDTH-1:0]   r_acc;
  logic [P_WIDTH-1:0]   r_mcand;
  logic [B_WIDTH-1:0]   r_mult;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_neg;
  logic                 r_busy;
  logic                 r_done;
  logic [P_WIDTH-1:0]   r_result;

  logic                 w_signed_op;
  logic [A_WIDTH-1:0]   w_mag1;
  logic [B_WIDTH-1:0]   w_mag2;
  logic                 w_neg;

  assign w_signed_op = (SIGNED_EN != 0) && i_Signed;
  assign w_mag1 = w_signed_op ? A_WIDTH'(mag64(64'($signed(i_Val1)))) : i_Val1;
  assign w_mag2 = w_signed_op ? B_WIDTH'(mag64(64'($signed(i_Val2)))) : i_Val2;
  // A zero operand clears the sign so the fixup never produces a negative zero.
  assign w_neg = w_signed_op && (i_Val1[A_WIDTH-1] ^ i_Val2[B_WIDTH-1])
                 && (|w_mag1) && (|w_mag2);

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mult   <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_Start) begin
            r_mcand <= P_WIDTH'(w_mag1);
            r_mult  <= w_mag2;
            r_neg   <= w_neg;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (r_mult[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand <= r_mcand << 1;
          r_mult  <= r_mult >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_result <= r_neg ? (~r_acc + 1'b1) : r_acc;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_Busy   = r_busy;
  assign o_Done   = r_done;
  assign o_Result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench: directed corner cases plus randomized operands against an arithmetic model.
`default_nettype none

module tb_seq_shift_add_multiplier;

  logic        clk;
  logic        rst_n, start, sgn;
  logic [8:0]  val1;
  logic [4:0]  val2;
  logic        busy, done;
  logic [13:0] result;

  logic        w_rst_n, w_start, w_sgn;
  logic [15:0] w_val1;
  logic [7:0]  w_val2;
  logic        w_busy, w_done;
  logic [23:0] w_result;

  int n_tests = 0;
  int n_fail  = 0;

  seq_shift_add_multiplier #(.A_WIDTH(9), .B_WIDTH(5), .SIGNED_EN(1)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start), .i_Signed(sgn),
    .i_Val1(val1), .i_Val2(val2),
    .o_Busy(busy), .o_Done(done), .o_Result(result)
  );

  seq_shift_add_multiplier #(.A_WIDTH(16), .B_WIDTH(8), .SIGNED_EN(0)) dut_w (
    .i_Clk(clk), .i_Rst_n(w_rst_n), .i_Start(w_start), .i_Signed(w_sgn),
    .i_Val1(w_val1), .i_Val2(w_val2),
    .o_Busy(w_busy), .o_Done(w_done), .o_Result(w_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Plain integer product of the operands as the mode defines them, reduced to aw+bw bits.
  function automatic longint unsigned ref_mul(input longint unsigned a, input longint unsigned b,
                                               input int aw, input int bw, input bit s);
    longint sa, sb, p;
    longint unsigned mask;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a >= (64'd1 << (aw - 1))) sa = sa - (longint'(1) << aw);
    if (s && b >= (64'd1 << (bw - 1))) sb = sb - (longint'(1) << bw);
    p    = sa * sb;
    mask = (64'd1 << (aw + bw)) - 1;
    return longint'(p) & mask;
  endfunction

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_op(input logic [8:0] a, input logic [4:0] b, input logic s,
                       input logic [13:0] exp, input string tag);
    int cyc;
    int busy_n;
    @(negedge clk);
    start = 1'b1; val1 = a; val2 = b; sgn = s;
    @(negedge clk);
    start = 1'b0; val1 = 9'($urandom); val2 = 5'($urandom); sgn = 1'($urandom);
    cyc = 0; busy_n = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_n++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd6);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'd6);
    check(tag, 64'(result), 64'(exp));
    @(negedge clk);
    check({tag, "_pulse"}, 64'(done), 64'd0);
  endtask

  typedef struct {
    logic [8:0]  a;
    logic [4:0]  b;
    logic        s;
    logic [13:0] exp;
  } vec_t;

  initial begin
    vec_t vecs[7];
    int cyc;
    int dones;
    logic [8:0] ra;
    logic [4:0] rb;
    logic       rs;

    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; val1 = '0; val2 = '0;
    w_rst_n = 1'b0; w_start = 1'b0; w_sgn = 1'b0; w_val1 = '0; w_val2 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_w_result", 64'(w_result), 64'd0);
    rst_n = 1'b1; w_rst_n = 1'b1;

    vecs[0] = '{9'd511,  5'd31,  1'b0, 14'h3DE1};
    vecs[1] = '{9'h100,  5'h10,  1'b1, 14'h1000};
    vecs[2] = '{9'h1FF,  5'd15,  1'b1, 14'h3FF1};
    vecs[3] = '{9'd0,    5'd31,  1'b1, 14'h0000};
    vecs[4] = '{9'd300,  5'd1,   1'b0, 14'd300};
    vecs[5] = '{9'h100,  5'd15,  1'b1, 14'h3100};
    vecs[6] = '{9'h1FF,  5'h1F,  1'b0, 14'h3DE1};
    foreach (vecs[i]) do_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, $sformatf("dir%0d", i));

    for (int i = 0; i < 60; i++) begin
      ra = 9'($urandom); rb = 5'($urandom); rs = 1'($urandom);
      if (i % 10 == 0) ra = 9'h100;
      if (i % 10 == 1) rb = 5'h10;
      do_op(ra, rb, rs, 14'(ref_mul(64'(ra), 64'(rb), 9, 5, rs)), $sformatf("rnd%0d", i));
    end

    // A start while busy is dropped; a start during the done cycle is taken.
    @(negedge clk);
    start = 1'b1; val1 = 9'd123; val2 = 5'd7; sgn = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; val1 = 9'd5; val2 = 5'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("busy_ign_latency", 64'(cyc), 64'd3);
    check("busy_ign_result", 64'(result), 64'd861);
    start = 1'b1; val1 = 9'h1FF; val2 = 5'h1F; sgn = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_done_low", 64'(done), 64'd0);
    wait_done(cyc);
    check("b2b_latency", 64'(cyc), 64'd6);
    check("b2b_result", 64'(result), 64'd1);

    // Reset in the middle of RUN aborts silently.
    @(negedge clk);
    start = 1'b1; val1 = 9'd77; val2 = 5'd9; sgn = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    rst_n = 1'b1;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);

    // Wide unsigned-only instance: i_Signed must have no effect.
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] a;
      logic [7:0]  b;
      a = 16'($urandom); b = 8'($urandom);
      if (i == 0) begin a = 16'hFFFF; b = 8'hFF; end
      @(negedge clk);
      w_start = 1'b1; w_val1 = a; w_val2 = b; w_sgn = 1'($urandom);
      @(negedge clk);
      w_start = 1'b0; w_val1 = 16'($urandom); w_val2 = 8'($urandom);
      cyc = 0;
      while (!w_done && cyc < 30) begin
        @(negedge clk);
        cyc++;
      end
      check($sformatf("wide%0d_latency", i), 64'(cyc), 64'd9);
      check($sformatf("wide%0d", i), 64'(w_result), ref_mul(64'(a), 64'(b), 16, 8, 1'b0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
